// File: rtl/dir_key_encoder.sv
// dir_key_encoder: debounced snake-game keys -> filtered 2-entry direction queue with valid/ready pop.
// Define REVERSE_FILTER_EN to also reject presses opposite to the reference direction.
module dir_key_encoder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W = 16
) (
  input  logic       SYS_CLK,
  input  logic       RST,
  input  logic       UP,
  input  logic       DOWN,
  input  logic       LEFT,
  input  logic       RIGHT,
  input  logic       PAUSE,
  input  logic       dir_ready,
  output logic       dir_valid,
  output logic [1:0] dir,
  output logic [1:0] cur_dir,
  output logic       paused,
  output logic [7:0] drop_cnt
);
  logic [4:0] raw, s1, s2, deb, deb_d, press;
  logic [CNT_W-1:0] cnt [5];
  logic [1:0] q1, cand, ref_dir, n_q0, n_q1, count, n_count;
  logic single, any_dir, bad, push, drop, pop, flush;

  assign raw = {PAUSE, RIGHT, LEFT, DOWN, UP};

  always_ff @(posedge SYS_CLK or posedge RST)
    if (RST) begin
      s1 <= '0;
      s2 <= '0;
      deb <= '0;
      deb_d <= '0;
      press <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      deb_d <= deb;
      press <= deb & ~deb_d;
      for (int i = 0; i < 5; i++)
        if (s2[i] == deb[i]) cnt[i] <= '0;
        else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          cnt[i] <= '0;
          deb[i] <= ~deb[i];
        end else cnt[i] <= cnt[i] + 1'b1;
    end

  // a press only counts when no other direction is held or pressed alongside it
  assign single  = $onehot(press[3:0]) && ((deb[3:0] & ~press[3:0]) == 4'b0);
  assign cand    = {press[3] | press[2], press[3] | press[1]};
  assign ref_dir = count == 2'd2 ? q1 : count == 2'd1 ? dir : cur_dir;
  assign any_dir = |press[3:0] & ~paused & ~press[4];
  assign pop     = dir_valid & dir_ready;
  assign flush   = press[4] & ~paused;
`ifdef REVERSE_FILTER_EN
  assign bad = ~single | (cand == ref_dir) | (cand == (ref_dir ^ 2'b01)) | (count == 2'd2 & ~pop);
`else
  assign bad = ~single | (cand == ref_dir) | (count == 2'd2 & ~pop);
`endif
  assign push = any_dir & ~bad;
  assign drop = any_dir & bad;

  // a flush keeps the head register so dir holds its last value
  always_comb begin
    n_q0 = dir;
    n_q1 = q1;
    n_count = count;
    if (pop & ~flush) begin
      n_q0 = count == 2'd2 ? q1 : dir;
      n_count = count - 2'd1;
    end
    if (push) begin
      if (n_count == 2'd0) n_q0 = cand;
      else n_q1 = cand;
      n_count = n_count + 2'd1;
    end
    if (flush) n_count = 2'd0;
  end

  always_ff @(posedge SYS_CLK or posedge RST)
    if (RST) begin
      count <= '0;
      dir <= '0;
      q1 <= '0;
      dir_valid <= 1'b0;
      cur_dir <= '0;
      paused <= 1'b0;
      drop_cnt <= '0;
    end else begin
      count <= n_count;
      dir <= n_q0;
      q1 <= n_q1;
      dir_valid <= n_count != 2'd0;
      if (pop) cur_dir <= dir;
      if (press[4]) paused <= ~paused;
      if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
    end
endmodule

// File: tb/tb_dir_key_encoder.sv
// tb_dir_key_encoder: directed + random key presses checked every cycle against a queue-based model.
module tb_dir_key_encoder;
  localparam int D = 4;
  logic SYS_CLK = 0;
  logic RST = 1;
  logic dir_ready = 0;
  logic [4:0] keys = '0;
  logic dir_valid, paused;
  logic [1:0] dir, cur_dir;
  logic [7:0] drop_cnt;
  int vecs = 0, errs = 0;
  int mq[$];
  int m_cur = 0, m_last = 0, m_paused = 0, m_drop = 0;
  int edge_n = 0, pend_edge = -1, pend_key = 0;
  bit rnd = 0;

  always #5 SYS_CLK = ~SYS_CLK;

  dir_key_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
    .SYS_CLK(SYS_CLK), .RST(RST),
    .UP(keys[0]), .DOWN(keys[1]), .LEFT(keys[2]), .RIGHT(keys[3]), .PAUSE(keys[4]),
    .dir_ready(dir_ready), .dir_valid(dir_valid), .dir(dir), .cur_dir(cur_dir),
    .paused(paused), .drop_cnt(drop_cnt)
  );

  task automatic chk(string tag, logic [7:0] got, logic [7:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
    end
  endtask

  task automatic check_all();
    chk("dir_valid", 8'(dir_valid), 8'(mq.size() > 0));
    chk("dir", 8'(dir), 8'(m_last));
    chk("cur_dir", 8'(cur_dir), 8'(m_cur));
    chk("paused", 8'(paused), 8'(m_paused));
    chk("drop_cnt", drop_cnt, 8'(m_drop));
  endtask

  task automatic model_reset();
    mq.delete();
    m_cur = 0; m_last = 0; m_paused = 0; m_drop = 0; pend_edge = -1;
  endtask

  // key 0..3 direction, 4 pause, 5 two directions pressed together
  task automatic model_edge();
    bit pop, have, rej;
    int r;
    pop = dir_ready && mq.size() > 0;
    if (edge_n == pend_edge && pend_key == 4) begin
      if (pop) m_cur = mq[0];
      if (m_paused == 0) mq.delete();
      else if (pop) void'(mq.pop_front());
      m_paused = 1 - m_paused;
    end else begin
      have = edge_n == pend_edge && m_paused == 0;
      rej = 0;
      if (have) begin
        r = mq.size() > 0 ? mq[$] : m_cur;
        if (pend_key == 5) rej = 1;
        else rej = pend_key == r || (mq.size() == 2 && !pop);
`ifdef REVERSE_FILTER_EN
        if (pend_key != 5 && pend_key != r && pend_key / 2 == r / 2) rej = 1;
`endif
      end
      if (pop) m_cur = mq.pop_front();
      if (have) begin
        if (rej) m_drop = m_drop < 255 ? m_drop + 1 : 255;
        else mq.push_back(pend_key);
      end
    end
    if (mq.size() > 0) m_last = mq[0];
  endtask

  task automatic step();
    @(posedge SYS_CLK);
    edge_n++;
    if (!RST) model_edge();
    #1 check_all();
    if (rnd) dir_ready = $urandom_range(0, 3) == 0;
  endtask

  task automatic press(int k);
    if (k == 5) keys = 5'b00101;
    else keys[k] = 1'b1;
    pend_key = k;
    pend_edge = edge_n + 1 + D + 3;
    repeat (D + 5) step();
    keys = '0;
    repeat (D + 4) step();
  endtask

  task automatic pop_one();
    dir_ready = 1;
    step();
    dir_ready = 0;
  endtask

  initial begin
    int k;
    #2 check_all();
    RST = 0;
    repeat (2) step();
    press(3);
    pop_one();
    for (int i = 0; i < 6; i++) begin
      keys[2] = ~keys[2];
      repeat (2) step();
    end
    keys = '0;
    repeat (D + 6) step();
    press(0);
    pop_one();
    press(1);
    press(2);
    repeat (3) pop_one();
    press(3);
    press(0);
    press(2);
    pop_one();
    pop_one();
    press(3);
    press(4);
    press(3);
    press(4);
    press(5);
    repeat (2) pop_one();
    keys[3] = 1;
    repeat (3) step();
    #2 RST = 1;
    model_reset();
    #1 check_all();
    repeat (2) step();
    RST = 0;
    pend_key = 3;
    pend_edge = edge_n + 1 + D + 3;
    repeat (D + 5) step();
    keys = '0;
    repeat (D + 4) step();
    rnd = 1;
    repeat (80) begin
      k = $urandom_range(0, 9);
      press(k < 8 ? k % 4 : k == 8 ? 4 : 5);
    end
    rnd = 0;
    if (m_paused != 0) press(4);
    dir_ready = 1;
    repeat (4) step();
    dir_ready = 0;
    k = m_cur;
    repeat (260) press(k);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/dir_key_encoder.md
Name: dir_key_encoder

Overview:
- Input-side front end for the 8x8 LED snake game.
- Conditions the raw UP/DOWN/LEFT/RIGHT/PAUSE buttons: synchronise, debounce, press-edge detect.
- Turns presses into direction commands, filters illegal ones, and queues them in a 2-entry FIFO.
- The game core pops one command per game tick through a valid/ready handshake. This replaces level-sensitive button sampling inside the game logic.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive SYS_CLK cycles a synced key must differ from its debounced level before the level flips (1 ms at 50 MHz).
- CNT_W, 16: debounce counter width; must hold DEBOUNCE_CYCLES.

Ports:
- SYS_CLK  input  1  system clock, single clock domain.
- RST  input  1  reset; asynchronous, active-high.
- UP, DOWN, LEFT, RIGHT, PAUSE  input  1 each  raw buttons, active-high, asynchronous to SYS_CLK.
- dir_valid  output  1  FIFO non-empty.
- dir  output  2  FIFO head direction: 00 up, 01 down, 10 left, 11 right.
- dir_ready  input  1  consumer accepts head this cycle.
- cur_dir  output  2  last direction transferred to the consumer.
- paused  output  1  pause state, toggled by PAUSE presses.
- drop_cnt  output  8  saturating count of rejected direction presses.

Behaviour:
- Reset (async, RST=1), applied immediately and held while RST is high:
  - dir_valid=0, dir=00, cur_dir=00, paused=0, drop_cnt=0.
  - FIFO empty; sync flops, debounced levels and counters all 0.
- Synchroniser: 2 flops per key.
- Debounce, per key:
  - While synced level equals the debounced level, the counter is held at 0.
  - Otherwise the counter increments each cycle. When it reaches DEBOUNCE_CYCLES, the debounced level flips and the counter returns to 0.
  - Any return to equality before that clears the counter.
- Press pulse: one cycle, on a 0->1 transition of the debounced level.
- Latency: a clean raw rise sampled at edge 0 gives dir_valid=1 after edge DEBOUNCE_CYCLES+3.
- Candidate direction: a direction key's press pulse, with all other direction debounced levels 0.
  - Two or more press pulses in the same cycle, or a press while another direction is held, count as a reject.
- Reference direction: the FIFO tail if count>0, else cur_dir. It is evaluated on the state before the current edge.
- Candidate rejected (drop_cnt+1, saturating at 255) when any of these holds:
  - it equals the reference (duplicate);
  - it is the opposite of the reference (up<->down, left<->right);
  - the FIFO is full and not popping this cycle.
- Otherwise the candidate is pushed.
- Pop: on dir_valid & dir_ready, the head is removed and cur_dir<=head.
- Simultaneous push and pop is legal at every count. When count=2, the push is accepted because of the pop.
- dir and dir_valid are registered FIFO outputs. dir holds its last value when empty.
- PAUSE press pulse toggles paused.
  - On the 0->1 transition the FIFO is flushed that edge (dir_valid=0 next cycle). Any push that cycle is discarded.
  - While paused=1, direction presses are ignored: not queued, not counted. Pops are still honoured.
- PAUSE and a direction press in the same cycle: pause wins and the direction is ignored.
- RST mid-debounce or mid-handshake: everything returns to reset values; a key still held after release of RST needs a full debounce and produces a press.

Optional Feature:
- Macro: REVERSE_FILTER_EN.
- Defined: the opposite-direction rejection above applies.
- Undefined: opposites are queued; only duplicate, multi-key and full rejects apply. The game core must then handle self-collision on reversal.

Test Plan:
- Reset: assert RST mid-run -> all outputs 0 immediately (dir_valid=0, cur_dir=00, drop_cnt=0, paused=0).
- DEBOUNCE_CYCLES=4. RIGHT raised at edge 0 and held, dir_ready=0 -> dir_valid=1, dir=11 after edge 7. Then dir_ready=1 for one cycle -> cur_dir=11, dir_valid=0.
- LEFT toggling every 2 cycles for 12 cycles, then low -> dir_valid stays 0, drop_cnt=0.
- cur_dir=00, REVERSE_FILTER_EN defined: press DOWN -> drop_cnt=1, no push. Press LEFT -> dir=10 queued. Undefined: DOWN -> dir=01 queued.
- dir_ready=0, cur_dir=00: press RIGHT, UP, LEFT sequentially -> FIFO holds 11,00; LEFT dropped (drop_cnt+1). Pop twice -> 11 then 00, cur_dir=00.
- Queue holds one entry. Press PAUSE -> paused=1, dir_valid=0. Press RIGHT -> no push, drop_cnt unchanged. Press PAUSE -> paused=0.
